// File: rtl/quad_mux_arbiter_if.sv
// Requester / consumer bundle for the shared 4-bit 2:1 mux arbiter.
// master drives requests and data, slave is the arbiter itself.
interface quad_mux_arbiter_if;
    logic       req_a;
    logic       req_b;
    logic [3:0] A;
    logic [3:0] B;
    logic       gnt_a;
    logic       gnt_b;
    logic       G;
    logic       nEN;
    logic [3:0] out;
    logic       out_vld;
    logic       revoked;

    modport master (
        output req_a, req_b, A, B,
        input  gnt_a, gnt_b, G, nEN,
        input  out, out_vld, revoked
    );

    modport slave (
        input  req_a, req_b, A, B,
        output gnt_a, gnt_b, G, nEN,
        output out, out_vld, revoked
    );
endinterface

// File: rtl/quad_mux_arbiter.sv
// Round-robin two-requester arbiter with dead gap for the 4-bit mux.
// QUAD_MUX_ARB_WATCHDOG_EN adds a MAX_HOLD ownership watchdog.
module quad_mux_arbiter #(
    parameter int unsigned DEAD_CYC = 1,
    parameter int unsigned MAX_HOLD = 16
) (
    input logic               clk,
    input logic               nRST,
    quad_mux_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        GAP   = 2'd3
    } state_t;

`ifdef QUAD_MUX_ARB_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    localparam logic [3:0] GAP_LD   = 4'(DEAD_CYC);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    state_t     state_q;
    state_t     state_d;
    logic       last_b_q;
    logic       last_b_d;
    logic [3:0] gap_q;
    logic [3:0] gap_d;
    logic [7:0] hold_q;
    logic [7:0] hold_d;
    logic [7:0] hold_inc;
    logic       hold_hit;
    logic       rev_q;
    logic       rev_d;
    logic       g_q;
    logic       gnt_a;
    logic       gnt_b;
    logic       nen;
    logic [3:0] out_q;
    logic       vld_q;

    assign hold_inc = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
    // Current owned cycle is the MAX_HOLD-th of this tenure.
    assign hold_hit = WDOG_EN && (hold_q >= HOLD_LIM);

    // State, counters and the select register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            gap_q    <= 4'd0;
            hold_q   <= 8'd0;
            rev_q    <= 1'b0;
            g_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            gap_q    <= gap_d;
            hold_q   <= hold_d;
            rev_q    <= rev_d;
            if (state_d == OWN_A)
                g_q <= 1'b0;
            else if (state_d == OWN_B)
                g_q <= 1'b1;
        end
    end

    // Next-state: round-robin grant, hold while requested, dead gap.
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        gap_d    = gap_q;
        hold_d   = hold_q;
        rev_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || last_b_q)) begin
                    state_d = OWN_A;
                    hold_d  = 8'd0;
                end else if (bus.req_b) begin
                    state_d = OWN_B;
                    hold_d  = 8'd0;
                end
            end
            OWN_A: begin
                hold_d = hold_inc;
                if (!bus.req_a || hold_hit) begin
                    state_d  = GAP;
                    last_b_d = 1'b0;
                    gap_d    = GAP_LD;
                    rev_d    = bus.req_a;
                end
            end
            OWN_B: begin
                hold_d = hold_inc;
                if (!bus.req_b || hold_hit) begin
                    state_d  = GAP;
                    last_b_d = 1'b1;
                    gap_d    = GAP_LD;
                    rev_d    = bus.req_b;
                end
            end
            GAP: begin
                if (gap_q <= 4'd1)
                    state_d = IDLE;
                else
                    gap_d = gap_q - 4'd1;
            end
        endcase
    end

    // Output decode straight from the state register.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        unique case (state_q)
            OWN_A:   gnt_a = 1'b1;
            OWN_B:   gnt_b = 1'b1;
            default: ;
        endcase
        nen = !(gnt_a || gnt_b);
    end

    // Capture the selected data on every enabled cycle.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            out_q <= 4'h0;
            vld_q <= 1'b0;
        end else if (!nen) begin
            out_q <= g_q ? bus.B : bus.A;
            vld_q <= 1'b1;
        end else begin
            vld_q <= 1'b0;
        end
    end

    assign bus.gnt_a   = gnt_a;
    assign bus.gnt_b   = gnt_b;
    assign bus.G       = g_q;
    assign bus.nEN     = nen;
    assign bus.out     = out_q;
    assign bus.out_vld = vld_q;
    assign bus.revoked = WDOG_EN & rev_q;

endmodule

// File: tb/tb_quad_mux_arbiter.sv
// Scoreboard bench for quad_mux_arbiter: stimulus queues the expected
// outputs of each edge, a monitor pops and compares after the edge.
module tb_quad_mux_arbiter;

    logic clk  = 1'b0;
    logic nRST = 1'b1;

    quad_mux_arbiter_if bus ();

    quad_mux_arbiter #(
        .DEAD_CYC (1),
        .MAX_HOLD (4)
    ) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ga;
        logic       gb;
        logic       g;
        logic       nen;
        logic       vld;
        logic [3:0] out;
        logic       rev;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic void chk(input string name,
                                input logic [3:0] act,
                                input logic [3:0] req);
        n_chk++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, req);
    endfunction

    function automatic exp_t mk(input logic ga, input logic gb,
                                input logic g, input logic nen,
                                input logic vld, input logic [3:0] o,
                                input logic rev);
        exp_t e;
        e.ga  = ga;
        e.gb  = gb;
        e.g   = g;
        e.nen = nen;
        e.vld = vld;
        e.out = o;
        e.rev = rev;
        return e;
    endfunction

    task automatic step(input logic ra, input logic rb,
                        input logic [3:0] a, input logic [3:0] b,
                        input exp_t e);
        @(negedge clk);
        bus.req_a = ra;
        bus.req_b = rb;
        bus.A     = a;
        bus.B     = b;
        exp_q.push_back(e);
    endtask

    // One 3-cycle tenure of owner o (0=A, 1=B) already granted,
    // release, gap, idle, then the other requester is granted.
    task automatic round(input logic o,
                         input logic [3:0] a, input logic [3:0] b);
        logic [3:0] d;
        d = o ? b : a;
        step(1'b1, 1'b1, a, b, mk(!o, o, o, 1'b0, 1'b1, d, 1'b0));
        step(1'b1, 1'b1, a, b, mk(!o, o, o, 1'b0, 1'b1, d, 1'b0));
        step(o, !o, a, b, mk(1'b0, 1'b0, o, 1'b1, 1'b1, d, 1'b0));
        step(1'b1, 1'b1, a, b, mk(1'b0, 1'b0, o, 1'b1, 1'b0, d, 1'b0));
        step(1'b1, 1'b1, a, b, mk(o, !o, !o, 1'b0, 1'b0, d, 1'b0));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " gnt_a"}, {3'b0, bus.gnt_a}, 4'h0);
        chk({tag, " gnt_b"}, {3'b0, bus.gnt_b}, 4'h0);
        chk({tag, " G"}, {3'b0, bus.G}, 4'h0);
        chk({tag, " nEN"}, {3'b0, bus.nEN}, 4'h1);
        chk({tag, " out"}, bus.out, 4'h0);
        chk({tag, " out_vld"}, {3'b0, bus.out_vld}, 4'h0);
        chk({tag, " revoked"}, {3'b0, bus.revoked}, 4'h0);
    endtask

    initial begin : monitor
        exp_t e;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                chk($sformatf("c%0d gnt_a", cyc), {3'b0, bus.gnt_a}, {3'b0, e.ga});
                chk($sformatf("c%0d gnt_b", cyc), {3'b0, bus.gnt_b}, {3'b0, e.gb});
                chk($sformatf("c%0d G", cyc), {3'b0, bus.G}, {3'b0, e.g});
                chk($sformatf("c%0d nEN", cyc), {3'b0, bus.nEN}, {3'b0, e.nen});
                chk($sformatf("c%0d out_vld", cyc), {3'b0, bus.out_vld}, {3'b0, e.vld});
                chk($sformatf("c%0d out", cyc), bus.out, e.out);
                chk($sformatf("c%0d revoked", cyc), {3'b0, bus.revoked}, {3'b0, e.rev});
                chk($sformatf("c%0d excl", cyc),
                    {3'b0, bus.gnt_a & bus.gnt_b}, 4'h0);
                chk($sformatf("c%0d nen_iff", cyc),
                    {3'b0, bus.nEN}, {3'b0, !(bus.gnt_a ^ bus.gnt_b)});
            end
        end
    end

    initial begin : stim
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        bus.A     = 4'h5;
        bus.B     = 4'hA;
        #1 nRST = 1'b0;
        #1 chk_reset("rst");
        repeat (2) @(posedge clk);
        #2 nRST = 1'b1;

        // Both requesting out of reset: A wins the first tie.
        step(1, 1, 4'h5, 4'hA, mk(1, 0, 0, 0, 0, 4'h0, 0));
        step(1, 1, 4'h5, 4'hA, mk(1, 0, 0, 0, 1, 4'h5, 0));
        // A releases; last owned cycle still captures A.
        step(0, 1, 4'h6, 4'hA, mk(0, 0, 0, 1, 1, 4'h6, 0));
        step(0, 1, 4'h6, 4'hA, mk(0, 0, 0, 1, 0, 4'h6, 0));
        step(0, 1, 4'h6, 4'hA, mk(0, 1, 1, 0, 0, 4'h6, 0));

        // Alternating tenures.
        round(1'b1, 4'h3, 4'hC);
        round(1'b0, 4'h7, 4'h8);
        round(1'b1, 4'h9, 4'h1);
        round(1'b0, 4'h2, 4'hE);

        // B owns: drop everything, then a 1-cycle req_b pulse.
        step(0, 0, 4'h2, 4'hE, mk(0, 0, 1, 1, 1, 4'hE, 0));
        step(0, 0, 4'h2, 4'hE, mk(0, 0, 1, 1, 0, 4'hE, 0));
        step(0, 0, 4'h2, 4'hE, mk(0, 0, 1, 1, 0, 4'hE, 0));
        step(0, 1, 4'h2, 4'hD, mk(0, 1, 1, 0, 0, 4'hE, 0));
        step(0, 0, 4'h2, 4'hD, mk(0, 0, 1, 1, 1, 4'hD, 0));
        step(0, 0, 4'h2, 4'hD, mk(0, 0, 1, 1, 0, 4'hD, 0));
        step(0, 0, 4'h2, 4'hD, mk(0, 0, 1, 1, 0, 4'hD, 0));

        // Reset in the middle of a B tenure.
        step(0, 1, 4'h2, 4'hB, mk(0, 1, 1, 0, 0, 4'hD, 0));
        step(0, 1, 4'h2, 4'hB, mk(0, 1, 1, 0, 1, 4'hB, 0));
        @(posedge clk);
        #3;
        nRST      = 1'b0;
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        bus.A     = 4'h4;
        #1 chk_reset("midrst");
        @(posedge clk);
        #2 nRST = 1'b1;

        // A first after reset, then held with B waiting.
        step(1, 1, 4'h4, 4'hB, mk(1, 0, 0, 0, 0, 4'h0, 0));
        step(1, 1, 4'h4, 4'hB, mk(1, 0, 0, 0, 1, 4'h4, 0));
        step(1, 1, 4'h4, 4'hB, mk(1, 0, 0, 0, 1, 4'h4, 0));
        step(1, 1, 4'h4, 4'hB, mk(1, 0, 0, 0, 1, 4'h4, 0));
`ifdef QUAD_MUX_ARB_WATCHDOG_EN
        step(1, 1, 4'h4, 4'hB, mk(0, 0, 0, 1, 1, 4'h4, 1));
        step(1, 1, 4'h4, 4'hB, mk(0, 0, 0, 1, 0, 4'h4, 0));
        step(1, 1, 4'h4, 4'hB, mk(0, 1, 1, 0, 0, 4'h4, 0));
        step(1, 1, 4'h4, 4'hB, mk(0, 1, 1, 0, 1, 4'hB, 0));
`else
        repeat (6)
            step(1, 1, 4'h4, 4'hB, mk(1, 0, 0, 0, 1, 4'h4, 0));
`endif

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        chk("drain", {3'b0, exp_q.size() != 0}, 4'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
